// File: rtl/grf_scoreboard.sv
// General register file with write-first bypass and a per-register pending-write scoreboard.
// Optional macro GRF_DISPLAY_EN adds a simulation-only trace of every committed write.
module grf_scoreboard #(
    parameter int          CNT_W   = 2,
    parameter logic [31:0] RST_VAL = 32'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  RA1,
    input  logic [4:0]  RA2,
    input  logic        use1,
    input  logic        use2,
    output logic [31:0] RD1,
    output logic [31:0] RD2,
    input  logic [4:0]  A3,
    input  logic        WE3,
    input  logic [31:0] WD,
    input  logic [31:0] WPC,
    input  logic        retire,
    input  logic        issue,
    input  logic [4:0]  issue_reg,
    input  logic        flush,
    output logic        stall,
    output logic        sb_err
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;

    logic [31:0]            regs_reg [32];
    logic [31:0][CNT_W-1:0] cnt_all;
    logic [31:0]            err_vec;
    logic                   sb_err_reg;
    logic                   wr_en;
    logic [CNT_W-1:0]       rem1;
    logic [CNT_W-1:0]       rem2;
    logic                   busy1;
    logic                   busy2;
    logic                   wpc_unused;

    assign wr_en      = WE3 && (A3 != 5'd0);
    assign wpc_unused = ^WPC;

    // Entry 0 is never written; reads of $0 are forced to zero below.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) begin
                regs_reg[i] <= RST_VAL;
            end
        end else if (wr_en) begin
            regs_reg[A3] <= WD;
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_cnt
            localparam bit NONZERO = (gi != 0);
            logic             inc;
            logic             dec;
            logic [CNT_W-1:0] cnt_reg;

            assign inc = NONZERO && !flush && issue  && (issue_reg == 5'(gi));
            assign dec = NONZERO && !flush && retire && (A3 == 5'(gi));
            assign err_vec[gi] = (inc && !dec && (cnt_reg == CNT_MAX)) ||
                                 (dec && !inc && (cnt_reg == CNT_ZERO));
            assign cnt_all[gi] = cnt_reg;

            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    cnt_reg <= '0;
                end else if (inc && !dec && (cnt_reg != CNT_MAX)) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end else if (dec && !inc && (cnt_reg != CNT_ZERO)) begin
                    cnt_reg <= cnt_reg - 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sb_err_reg <= 1'b0;
        end else if (|err_vec) begin
            sb_err_reg <= 1'b1;
        end
    end

    always_comb begin
        RD1 = 32'h0;
        RD2 = 32'h0;
        if (RA1 != 5'd0) begin
            RD1 = (wr_en && (A3 == RA1)) ? WD : regs_reg[RA1];
        end
        if (RA2 != 5'd0) begin
            RD2 = (wr_en && (A3 == RA2)) ? WD : regs_reg[RA2];
        end
    end

    // A register retiring this cycle no longer counts as pending for the reader.
    assign rem1  = cnt_all[RA1] - CNT_W'(retire && (A3 == RA1));
    assign rem2  = cnt_all[RA2] - CNT_W'(retire && (A3 == RA2));
    assign busy1 = (RA1 != 5'd0) && (rem1 != CNT_ZERO);
    assign busy2 = (RA2 != 5'd0) && (rem2 != CNT_ZERO);
    assign stall = (use1 && busy1) || (use2 && busy2);
    assign sb_err = sb_err_reg;

`ifdef GRF_DISPLAY_EN
    always @(posedge clk) begin
        if (WE3 && (A3 != 5'd0) && !reset) begin
            $display("@%h: $%d <= %h", WPC, A3, WD);
        end
    end
`else
`endif

endmodule
